issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of queue entries (power of two, 4..32).
REQ-002 Parameter PREG_W, default 6, physical register tag width (64 physical registers).
REQ-003 Parameter PAYLOAD_W, default 64, opaque decoded-control payload width (alu_ctl, branch/mem fields, immediate), carried unmodified.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  renamed instruction offered by the rename stage.
REQ-007 in_ready  output  1  queue accepts the offered instruction this cycle.
REQ-008 in_payload  input  PAYLOAD_W  control payload.
REQ-009 in_rs_phys, in_rt_phys, in_rw_phys  input  PREG_W each  physical source/dest tags.
REQ-010 in_uses_rs, in_uses_rt, in_uses_rw  input  1 each  operand-use flags.
REQ-011 in_rs_busy, in_rt_busy  input  1 each  busy-table bit of each source at rename time.
REQ-012 wb_valid  input  1  writeback broadcast valid.
REQ-013 wb_phys  input  PREG_W  physical tag being written back.
REQ-014 flush  input  1  squash all queued instructions (from hazard control).
REQ-015 iss_valid  output  1  an entry is being offered for issue.
REQ-016 iss_ready  input  1  execute stage accepts the issue.
REQ-017 iss_payload, iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_uses_rw  output  widths as inputs  selected entry contents.
REQ-018 occupancy  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 Each entry SHALL hold: valid, payload, tags, use flags, rs_wait, rt_wait.
REQ-020 Insert SHALL occur on in_valid && in_ready && !flush into the lowest-index free slot; rs_wait = in_uses_rs && in_rs_busy && !(wb_valid && wb_phys==in_rs_phys); rt_wait likewise.
REQ-021 in_ready SHALL equal (occupancy < DEPTH), independent of same-cycle issue.
REQ-022 Wakeup: when wb_valid, every valid entry whose rs (rt) tag equals wb_phys SHALL clear rs_wait (rt_wait) at the edge.
REQ-023 An entry is ready when valid && !rs_wait && !rt_wait as registered; an entry inserted or woken at edge t SHALL be issuable no earlier than the cycle after t (minimum 1-cycle insert-to-issue latency).
REQ-024 iss_valid SHALL be 1 iff some entry is ready and flush is 0; iss_* outputs are combinational from the selected entry.
REQ-025 Selection SHALL pick the oldest ready entry using a DEPTH x DEPTH older-than matrix; on insert into slot k, older[j][k]=1 for all valid j and older[k][j]=0.
REQ-026 On iss_valid && iss_ready the selected entry SHALL be invalidated at the edge; a slot freed and inserted in the same cycle is not permitted (insert uses slots free before the edge).
REQ-027 Selected entry MAY change between cycles while iss_ready is 0.
REQ-028 flush SHALL invalidate all entries at the edge, drop any same-cycle insert, and force iss_valid to 0 in the flush cycle; occupancy is 0 the next cycle.
REQ-029 occupancy SHALL update as occupancy + insert - issue, saturation impossible by REQ-021.

Reset
REQ-030 While rst_n is 0: all valid bits and wait bits 0, older matrix 0, occupancy 0, in_ready 1, iss_valid 0, iss_* data 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately without completing a pending handshake.

Configuration
REQ-032 Macro ISSUE_QUEUE_AGE_ORDER_EN: defined -> oldest-ready selection per REQ-025; undefined -> older matrix removed and the lowest-index ready entry is selected; all other behaviour identical.

Verification
REQ-033 Reset, insert A (rs busy tag 5), B (no busy sources) -> B issues cycle after insert; A held; wb_phys=5 -> A issues one cycle later.
REQ-034 Insert 16 ready-blocked entries -> in_ready 0, occupancy 16; one issue -> in_ready 1 next cycle.
REQ-035 Insert with in_rs_busy=1 and wb_valid, wb_phys equal same cycle -> entry issuable next cycle, never stalls.
REQ-036 Three ready entries in slots 3,0,7 inserted in that order, iss_ready=1 -> issue order 3,0,7 with macro; 0,3,7 without.
REQ-037 flush with 5 entries plus concurrent insert -> iss_valid 0 that cycle, occupancy 0 next cycle, dropped insert never issues.
REQ-038 iss_ready held 0 for 4 cycles with one ready entry -> iss_valid stays 1, same payload, occupancy unchanged.

Source files
------------

// File: rtl/issue_queue.sv
// Out-of-order issue queue: tag-based wakeup, single issue port, lowest-free-slot insert.
// Define ISSUE_QUEUE_AGE_ORDER_EN for oldest-ready selection; otherwise lowest ready index wins.
module issue_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [PREG_W-1:0]          in_rs_phys,
    input  logic [PREG_W-1:0]          in_rt_phys,
    input  logic [PREG_W-1:0]          in_rw_phys,
    input  logic                       in_uses_rs,
    input  logic                       in_uses_rt,
    input  logic                       in_uses_rw,
    input  logic                       in_rs_busy,
    input  logic                       in_rt_busy,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_phys,
    input  logic                       flush,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [PREG_W-1:0]          iss_rs_phys,
    output logic [PREG_W-1:0]          iss_rt_phys,
    output logic [PREG_W-1:0]          iss_rw_phys,
    output logic                       iss_uses_rw,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rs_wait_q, rs_wait_d;
    logic [DEPTH-1:0]     rt_wait_q, rt_wait_d;
    logic [DEPTH-1:0]     uses_rs_q, uses_rt_q, uses_rw_q;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PREG_W-1:0]    rs_q [DEPTH];
    logic [PREG_W-1:0]    rt_q [DEPTH];
    logic [PREG_W-1:0]    rw_q [DEPTH];
    logic [CNT_W-1:0]     occ_q, occ_d;

    logic [DEPTH-1:0]     ready;
    logic [IDX_W-1:0]     ins_idx, sel_idx;
    logic                 sel_found;
    logic                 do_insert, do_issue;

    assign ready     = valid_q & ~rs_wait_q & ~rt_wait_q;
    assign in_ready  = (occ_q < CNT_W'(DEPTH));
    assign do_insert = in_valid && in_ready && !flush;
    assign iss_valid = sel_found && !flush;
    assign do_issue  = iss_valid && iss_ready;
    assign occupancy = occ_q;

    // Lowest-index free slot, judged on the pre-edge valid bits.
    always_comb begin
        ins_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) ins_idx = IDX_W'(i);
        end
    end

`ifdef ISSUE_QUEUE_AGE_ORDER_EN
    // older_q[j][i] set means entry j was inserted before entry i.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        logic blocked;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            blocked = 1'b0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (ready[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (ready[i] && !blocked) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < int'(DEPTH); j++) older_d[j] = older_q[j];
        if (flush) begin
            for (int j = 0; j < int'(DEPTH); j++) older_d[j] = '0;
        end else if (do_insert) begin
            for (int j = 0; j < int'(DEPTH); j++) older_d[j][ins_idx] = valid_q[j];
            older_d[ins_idx] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(DEPTH); j++) older_q[j] <= '0;
        end else begin
            for (int j = 0; j < int'(DEPTH); j++) older_q[j] <= older_d[j];
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        iss_payload = '0;
        iss_rs_phys = '0;
        iss_rt_phys = '0;
        iss_rw_phys = '0;
        iss_uses_rw = 1'b0;
        if (sel_found) begin
            iss_payload = payload_q[sel_idx];
            iss_rs_phys = rs_q[sel_idx];
            iss_rt_phys = rt_q[sel_idx];
            iss_rw_phys = rw_q[sel_idx];
            iss_uses_rw = uses_rw_q[sel_idx];
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rs_wait_d = rs_wait_q;
        rt_wait_d = rt_wait_q;
        occ_d     = occ_q + CNT_W'(do_insert) - CNT_W'(do_issue);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wb_valid && uses_rs_q[i] && rs_q[i] == wb_phys) rs_wait_d[i] = 1'b0;
            if (wb_valid && uses_rt_q[i] && rt_q[i] == wb_phys) rt_wait_d[i] = 1'b0;
        end
        if (do_issue) valid_d[sel_idx] = 1'b0;
        if (do_insert) begin
            valid_d[ins_idx]   = 1'b1;
            // Same-cycle writeback bypass so the entry never waits on a tag already produced.
            rs_wait_d[ins_idx] = in_uses_rs && in_rs_busy && !(wb_valid && wb_phys == in_rs_phys);
            rt_wait_d[ins_idx] = in_uses_rt && in_rt_busy && !(wb_valid && wb_phys == in_rt_phys);
        end
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rs_wait_q <= '0;
            rt_wait_q <= '0;
            occ_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_wait_q <= rs_wait_d;
            rt_wait_q <= rt_wait_d;
            occ_q     <= occ_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uses_rs_q <= '0;
            uses_rt_q <= '0;
            uses_rw_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                payload_q[i] <= '0;
                rs_q[i]      <= '0;
                rt_q[i]      <= '0;
                rw_q[i]      <= '0;
            end
        end else if (do_insert) begin
            uses_rs_q[ins_idx] <= in_uses_rs;
            uses_rt_q[ins_idx] <= in_uses_rt;
            uses_rw_q[ins_idx] <= in_uses_rw;
            payload_q[ins_idx] <= in_payload;
            rs_q[ins_idx]      <= in_rs_phys;
            rt_q[ins_idx]      <= in_rt_phys;
            rw_q[ins_idx]      <= in_rw_phys;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected issue payloads are queued and popped on each issue.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_payload;
    logic [5:0]  in_rs_phys, in_rt_phys, in_rw_phys;
    logic        in_uses_rs, in_uses_rt, in_uses_rw, in_rs_busy, in_rt_busy;
    logic        wb_valid;
    logic [5:0]  wb_phys;
    logic        flush;
    logic        iss_valid, iss_ready;
    logic [63:0] iss_payload;
    logic [5:0]  iss_rs_phys, iss_rt_phys, iss_rw_phys;
    logic        iss_uses_rw;
    logic [4:0]  occupancy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb [$];

    issue_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .in_rs_phys (in_rs_phys),
        .in_rt_phys (in_rt_phys),
        .in_rw_phys (in_rw_phys),
        .in_uses_rs (in_uses_rs),
        .in_uses_rt (in_uses_rt),
        .in_uses_rw (in_uses_rw),
        .in_rs_busy (in_rs_busy),
        .in_rt_busy (in_rt_busy),
        .wb_valid   (wb_valid),
        .wb_phys    (wb_phys),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_payload(iss_payload),
        .iss_rs_phys(iss_rs_phys),
        .iss_rt_phys(iss_rt_phys),
        .iss_rw_phys(iss_rw_phys),
        .iss_uses_rw(iss_uses_rw),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, so the negedge view predicts the next edge's handshake.
    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("issue_payload", iss_payload, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [63:0] pl, input logic [5:0] rs, input logic [5:0] rt,
                          input logic rs_busy, input logic rt_busy);
        in_valid   = 1'b1;
        in_payload = pl;
        in_rs_phys = rs;
        in_rt_phys = rt;
        in_rw_phys = 6'd33;
        in_uses_rs = 1'b1;
        in_uses_rt = 1'b1;
        in_uses_rw = 1'b1;
        in_rs_busy = rs_busy;
        in_rt_busy = rt_busy;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wake(input logic [5:0] tag);
        wb_valid = 1'b1;
        wb_phys  = tag;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic issue_one(input logic [63:0] exp);
        iss_ready = 1'b1;
        sb.push_back(exp);
        step();
        iss_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_payload = '0;
        in_rs_phys = '0; in_rt_phys = '0; in_rw_phys = '0;
        in_uses_rs = 1'b0; in_uses_rt = 1'b0; in_uses_rw = 1'b0;
        in_rs_busy = 1'b0; in_rt_busy = 1'b0;
        wb_valid = 1'b0; wb_phys = '0; flush = 1'b0; iss_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_iss_payload", iss_payload, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // A waits on tag 5, B is ready; B issues first, A after the writeback
        sb.push_back(64'hB);
        sb.push_back(64'hA);
        iss_ready = 1'b1;
        insert(64'hA, 6'd5, 6'd0, 1'b1, 1'b0);
        insert(64'hB, 6'd1, 6'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("b_iss_valid", 64'(iss_valid), 64'd1);
        check("b_payload", iss_payload, 64'hB);
        step();
        wb_valid = 1'b1;
        wb_phys  = 6'd5;
        @(negedge clk);
        check("a_held", 64'(iss_valid), 64'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("a_iss_valid", 64'(iss_valid), 64'd1);
        step();
        iss_ready = 1'b0;

        // Fill all 16 slots with blocked entries
        for (int i = 0; i < 16; i++) insert(64'h100 + 64'(i), 6'(20 + i), 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("full_occupancy", 64'(occupancy), 64'd16);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step();
        wake(6'd20);
        iss_ready = 1'b1;
        sb.push_back(64'h100);
        @(negedge clk);
        check("full_ready_during_issue", 64'(in_ready), 64'd0);
        step();
        iss_ready = 1'b0;
        @(negedge clk);
        check("after_issue_in_ready", 64'(in_ready), 64'd1);
        check("after_issue_occupancy", 64'(occupancy), 64'd15);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_full_occ", 64'(occupancy), 64'd0);
        step();

        // Busy sources woken by a same-cycle writeback never stall
        wb_valid = 1'b1;
        wb_phys  = 6'd9;
        insert(64'h500, 6'd9, 6'd9, 1'b1, 1'b1);
        wb_valid = 1'b0;
        @(negedge clk);
        check("bypass_iss_valid", 64'(iss_valid), 64'd1);
        check("bypass_payload", iss_payload, 64'h500);
        step();
        issue_one(64'h500);

        // Engineer ready entries in slots 3, 0, 7 inserted in that order
        for (int i = 0; i < 8; i++) insert(64'h200 + 64'(i), 6'(40 + i), 6'd0, 1'b1, 1'b0);
        wake(6'd43);
        issue_one(64'h203);
        insert(64'h300, 6'd50, 6'd0, 1'b1, 1'b0);
        wake(6'd40);
        issue_one(64'h200);
        insert(64'h301, 6'd51, 6'd0, 1'b1, 1'b0);
        wake(6'd47);
        issue_one(64'h207);
        insert(64'h302, 6'd52, 6'd0, 1'b1, 1'b0);
        wake(6'd50);
        wake(6'd51);
        wake(6'd52);
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        sb.push_back(64'h300);
        sb.push_back(64'h301);
`else
        sb.push_back(64'h301);
        sb.push_back(64'h300);
`endif
        sb.push_back(64'h302);
        iss_ready = 1'b1;
        step();
        step();
        step();
        iss_ready = 1'b0;

        // Five blocked entries remain; flush with a ready entry and a concurrent insert
        @(negedge clk);
        check("pre_flush_occ", 64'(occupancy), 64'd5);
        step();
        wake(6'd41);
        flush     = 1'b1;
        iss_ready = 1'b1;
        in_valid  = 1'b1;
        in_payload = 64'hDEAD;
        in_uses_rs = 1'b0;
        in_uses_rt = 1'b0;
        @(negedge clk);
        check("flush_iss_valid", 64'(iss_valid), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dropped_insert_silent", 64'(iss_valid), 64'd0);
        end
        step();
        iss_ready = 1'b0;

        // Held issue: selection and occupancy stable while iss_ready is low
        insert(64'h400, 6'd3, 6'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_iss_valid", 64'(iss_valid), 64'd1);
            check("hold_payload", iss_payload, 64'h400);
            check("hold_occupancy", 64'(occupancy), 64'd1);
            step();
        end
        check("hold_rw_phys", 64'({iss_uses_rw, iss_rw_phys}), 64'({1'b1, 6'd33}));
        issue_one(64'h400);

        // Reset mid-operation discards a pending handshake
        iss_ready = 1'b1;
        insert(64'h600, 6'd1, 6'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_iss_valid", 64'(iss_valid), 64'd0);
        check("midrst_occupancy", 64'(occupancy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_payload", iss_payload, 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_iss_valid", 64'(iss_valid), 64'd0);
        step();
        iss_ready = 1'b0;

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
